// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings plus
// the opcode-group helper that tells the FSM which ops run iteratively.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_MUL  = 3'b001,
      OP_DIV  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_PASS = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // One bit per opcode: set for the ops that use the multi-cycle shift datapath.
   localparam logic [7:0] ITER_OPS = 8'b0000_0110;

   function automatic logic is_iter(opcode_t op);
      return ITER_OPS[op];
   endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared DATA_W-step shift datapath for unsigned MUL (shift-add) and DIV
// (restoring shift-subtract). The hi/lo register pair holds the running
// product for MUL and remainder/quotient for DIV. Result ports carry the
// value produced by the current step, so they are final while done is high
// and the caller can capture them on the same edge the last step retires.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] prod_lo,
   output logic [DATA_W-1:0] prod_hi,
   output logic [DATA_W-1:0] quot,
   output logic [DATA_W-1:0] rem
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] b_q;
   logic              div_q;
   logic              busy_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              last_step;

   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_sh;
   logic              div_ge;
   logic [DATA_W-1:0] div_sub;

   assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

   // One iteration: MUL adds b into the high half when the multiplier LSB is
   // set and shifts right; DIV shifts the next dividend bit into the
   // remainder and subtracts b when it fits. With b==0 every trial fits, so
   // the quotient fills with ones and the remainder ends up equal to a.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
      div_sh  = {hi_q, lo_q[DATA_W-1]};
      div_ge  = (div_sh >= {1'b0, b_q});
      div_sub = div_sh[DATA_W-1:0] - b_q;
      if (div_q) begin
         hi_d = div_ge ? div_sub : div_sh[DATA_W-1:0];
         lo_d = {lo_q[DATA_W-2:0], div_ge};
      end else begin
         hi_d = mul_sum[DATA_W:1];
         lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
      end
   end

   // Load operands on start, then retire one step per cycle until the count runs out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         hi_q   <= '0;
         lo_q   <= a;
         b_q    <= b;
         div_q  <= op_div;
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + CNT_W'(1);
         if (last_step) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign done    = busy_q && last_step;
   assign prod_lo = lo_d;
   assign prod_hi = hi_d;
   assign quot    = lo_d;
   assign rem     = hi_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: IDLE/EXEC/DONE FSM, single-cycle arithmetic and
// logic ops, NZCV flags and registered outputs. MUL/DIV run on alu_iter_core.
// Build option: define ALU_SAT_EN to saturate ADD/SUB results on signed
// overflow instead of wrapping.
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        opCode,
   input  logic              ci,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out,
   output logic [DATA_W-1:0] rem,
   output logic              cero,
   output logic              neg,
   output logic              carry,
   output logic              ovf
);

   localparam int MSB = DATA_W - 1;

   state_t            state_q, state_d;
   opcode_t           op_q, op_d;
   logic              divz_q, divz_d;
   logic              alive_q;
   logic [DATA_W-1:0] out_q, out_d, rem_q, rem_d;
   logic              cero_q, cero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;

   opcode_t           op_in;
   logic              accept;
   logic [DATA_W:0]   add_full, sub_full;
   logic [DATA_W-1:0] sc_wrap, sc_res;
   logic              sc_c, sc_v;

   logic              core_done;
   logic [DATA_W-1:0] core_plo, core_phi, core_quot, core_rem;
   logic [DATA_W-1:0] it_res, it_rem;
   logic              it_c, it_v;

   assign op_in  = opcode_t'(opCode);
   assign accept = in_valid && in_ready;

   alu_iter_core #(.DATA_W(DATA_W)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && is_iter(op_in)),
      .op_div  (op_in == OP_DIV),
      .a       (a),
      .b       (b),
      .done    (core_done),
      .prod_lo (core_plo),
      .prod_hi (core_phi),
      .quot    (core_quot),
      .rem     (core_rem)
   );

   // Single-cycle results and flags, computed straight from the input operands.
   always_comb begin
      add_full = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
      sub_full = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
      sc_wrap  = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      case (op_in)
         OP_ADD: begin
            sc_wrap = add_full[DATA_W-1:0];
            sc_c    = add_full[DATA_W];
            sc_v    = (a[MSB] == b[MSB]) && (sc_wrap[MSB] != a[MSB]);
         end
         OP_SUB: begin
            sc_wrap = sub_full[DATA_W-1:0];
            sc_c    = sub_full[DATA_W];
            sc_v    = (a[MSB] != b[MSB]) && (sc_wrap[MSB] != a[MSB]);
         end
         OP_AND:  sc_wrap = a & b;
         OP_OR:   sc_wrap = a | b;
         OP_XOR:  sc_wrap = a ^ b;
         OP_PASS: sc_wrap = a;
         default: sc_wrap = '0;
      endcase
`ifdef ALU_SAT_EN
      // Overflow direction follows the sign of a for both ADD and SUB.
      if (sc_v) begin
         sc_res = a[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
         sc_res = sc_wrap;
      end
`else
      sc_res = sc_wrap;
`endif
   end

   // Final MUL/DIV results and flags taken from the core's last step.
   always_comb begin
      if (op_q == OP_DIV) begin
         it_res = core_quot;
         it_rem = core_rem;
         it_c   = 1'b0;
         it_v   = divz_q;
      end else begin
         it_res = core_plo;
         it_rem = '0;
         it_c   = |core_phi;
         it_v   = 1'b0;
      end
   end

   // FSM next state; output registers are only reloaded when entering DONE.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      divz_d  = divz_q;
      out_d   = out_q;
      rem_d   = rem_q;
      cero_d  = cero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d   = op_in;
               divz_d = (b == '0);
               if (is_iter(op_in)) begin
                  state_d = EXEC;
               end else begin
                  state_d = DONE;
                  out_d   = sc_res;
                  rem_d   = '0;
                  cero_d  = (sc_res == '0);
                  neg_d   = sc_res[MSB];
                  carry_d = sc_c;
                  ovf_d   = sc_v;
               end
            end
         end
         EXEC: begin
            if (core_done) begin
               state_d = DONE;
               out_d   = it_res;
               rem_d   = it_rem;
               cero_d  = (it_res == '0);
               neg_d   = it_res[MSB];
               carry_d = it_c;
               ovf_d   = it_v;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; alive_q holds in_ready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         divz_q  <= 1'b0;
         alive_q <= 1'b0;
         out_q   <= '0;
         rem_q   <= '0;
         cero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         divz_q  <= divz_d;
         alive_q <= 1'b1;
         out_q   <= out_d;
         rem_q   <= rem_d;
         cero_q  <= cero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = alive_q && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign rem       = rem_q;
   assign cero      = cero_q;
   assign neg       = neg_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DATA_W=8): expected results are pushed when an
// operation is accepted and popped when out_valid appears.
module tb_alu_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] opCode;
   logic       ci;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic [7:0] rem;
   logic       cero, neg, carry, ovf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] out;
      logic [7:0] rem;
      logic       z, n, c, v;
      int         lat;
   } exp_t;

   exp_t sbq[$];

   alu_seq #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opCode    (opCode),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .rem       (rem),
      .cero      (cero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [7:0] ma,
                                  input logic [7:0] mb, input logic mci);
      exp_t        e;
      logic [8:0]  s9;
      logic [15:0] p;
      e.op  = op;
      e.out = 8'h00;
      e.rem = 8'h00;
      e.c   = 1'b0;
      e.v   = 1'b0;
      e.lat = 1;
      case (op)
         3'b000: begin
            s9    = {1'b0, ma} + {1'b0, mb} + {8'h00, mci};
            e.out = s9[7:0];
            e.c   = s9[8];
            e.v   = (ma[7] == mb[7]) && (e.out[7] != ma[7]);
         end
         3'b011: begin
            s9    = {1'b0, ma} - {1'b0, mb};
            e.out = s9[7:0];
            e.c   = (ma >= mb);
            e.v   = (ma[7] != mb[7]) && (e.out[7] != ma[7]);
         end
         3'b001: begin
            p     = 16'(ma) * 16'(mb);
            e.out = p[7:0];
            e.c   = (p[15:8] != 8'h00);
            e.lat = 9;
         end
         3'b010: begin
            e.lat = 9;
            if (mb == 8'h00) begin
               e.out = 8'hFF;
               e.rem = ma;
               e.v   = 1'b1;
            end else begin
               e.out = ma / mb;
               e.rem = ma % mb;
            end
         end
         3'b100: e.out = ma & mb;
         3'b101: e.out = ma | mb;
         3'b110: e.out = ma ^ mb;
         default: e.out = ma;
      endcase
`ifdef ALU_SAT_EN
      if (e.v && (op == 3'b000 || op == 3'b011)) begin
         e.out = ma[7] ? 8'h80 : 8'h7F;
      end
`endif
      e.z = (e.out == 8'h00);
      e.n = e.out[7];
      return e;
   endfunction

   // Present an op at a negedge, wait for acceptance, push its expectation.
   task automatic send(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic vci, output longint acc_t);
      opCode   = op;
      a        = va;
      b        = vb;
      ci       = vci;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      @(posedge clk);
      acc_t = $time;
      sbq.push_back(model(op, va, vb, vci));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for out_valid, then pop the scoreboard and compare.
   task automatic wait_check(input longint acc_t);
      exp_t   e;
      longint lat;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         chk("exec_in_ready", in_ready, 0);
         @(negedge clk);
      end
      chk("out_valid", out_valid, 1);
      if (out_valid) begin
         if (sbq.size() == 0) begin
            chk("sb_empty", sbq.size(), 1);
         end else begin
            e   = sbq.pop_front();
            lat = ($time - 5 - acc_t) / 10 + 1;
            chk("latency", lat, e.lat);
            chk("out", out, e.out);
            chk("rem", rem, e.rem);
            chk("cero", cero, e.z);
            chk("neg", neg, e.n);
            chk("carry", carry, e.c);
            chk("ovf", ovf, e.v);
            chk("done_in_ready", in_ready, 0);
            $display("op=%0d a=%02h b=%02h -> out=%02h rem=%02h nzcv=%b%b%b%b lat=%0d",
                     e.op, a, b, out, rem, neg, cero, carry, ovf, lat);
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_valid", out_valid, 0);
      chk("idle_ready", in_ready, 1);
   endtask

   task automatic do_op(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                        input logic vci);
      longint t;
      send(op, va, vb, vci, t);
      wait_check(t);
      release_out();
   endtask

   initial begin
      longint t;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'h00;
      b         = 8'h00;
      opCode    = 3'b000;
      ci        = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", {rem, out}, 16'h0000);
      chk("rst_flags", {cero, neg, carry, ovf}, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", in_ready, 0);
      @(negedge clk);
      chk("rel_in_ready_high", in_ready, 1);

      do_op(3'b000, 8'h7F, 8'h01, 1'b0);   // signed overflow
      do_op(3'b000, 8'hFF, 8'h01, 1'b1);   // carry out with ci
      do_op(3'b011, 8'h05, 8'h05, 1'b0);   // zero result
      do_op(3'b011, 8'h03, 8'h05, 1'b0);   // borrow
      do_op(3'b011, 8'h80, 8'h01, 1'b0);   // negative overflow
      do_op(3'b001, 8'd20, 8'd13, 1'b0);   // product high half nonzero
      do_op(3'b001, 8'd15, 8'd15, 1'b0);
      do_op(3'b001, 8'hFF, 8'hFF, 1'b0);
      do_op(3'b010, 8'd100, 8'd7, 1'b0);
      do_op(3'b010, 8'd9, 8'd0, 1'b0);     // divide by zero
      do_op(3'b010, 8'd5, 8'd200, 1'b0);
      do_op(3'b101, 8'hA0, 8'h05, 1'b0);
      do_op(3'b110, 8'hFF, 8'h0F, 1'b0);
      do_op(3'b111, 8'h00, 8'h33, 1'b1);

      // Backpressure: result held, concurrent request ignored.
      send(3'b100, 8'hF0, 8'h3C, 1'b0, t);
      wait_check(t);
      opCode   = 3'b000;
      a        = 8'h11;
      b        = 8'h22;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out", out, 8'h30);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      release_out();
      @(negedge clk);
      chk("bp_no_extra", out_valid, 0);

      // Reset during the fourth cycle of a DIV.
      send(3'b010, 8'd100, 8'd7, 1'b0, t);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_out", {rem, out}, 16'h0000);
      chk("mid_rst_flags", {cero, neg, carry, ovf}, 4'b0000);
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_ready_low", in_ready, 0);
      @(negedge clk);
      chk("mid_rel_ready_high", in_ready, 1);
      do_op(3'b000, 8'h01, 8'h01, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational 4-op ALU.
- Adds valid/ready flow control, a registered result and a full NZCV flag set.
- Adds an iterative multiplier and divider that share one shift datapath, plus logic ops.
- Sits between the register-file read stage and writeback of the processor datapath; one operation in flight at a time.

Parameters:
DATA_W, 8, operand/result width in bits (>=2)
CNT_W, $clog2(DATA_W+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/opCode valid
in_ready  out  1  block can accept an operation
a  in  DATA_W  operand A (unsigned for MUL/DIV)
b  in  DATA_W  operand B
opCode  in  3  operation select
ci  in  1  carry-in, used by ADD only
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
out  out  DATA_W  result
rem  out  DATA_W  DIV remainder; 0 for other ops
cero  out  1  zero flag
neg  out  1  result MSB
carry  out  1  carry flag
ovf  out  1  signed overflow, or divide-by-zero for DIV

Behaviour:
- Reset: asynchronous, active-low; clock single.
  - Asserting rst_n=0 at any time, including mid-iteration, immediately gives state=IDLE, in_ready=0 while in reset, out_valid=0, and out/rem/cero/neg/carry/ovf=0.
  - in_ready rises the first cycle after release.
- Opcodes: 000 ADD (a+b+ci), 001 MUL, 010 DIV, 011 SUB (a-b), 100 AND, 101 OR, 110 XOR, 111 PASS_A.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&&in_ready, operands and opCode are latched. Single-cycle ops go to DONE. MUL/DIV go to EXEC with cnt=0.
  - EXEC: in_ready=0. One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. After DATA_W steps (cnt==DATA_W-1), go to DONE.
  - DONE: out_valid=1, outputs held stable. When out_ready=1, go to IDLE. No new accept occurs in the same cycle.
- Latency (acceptance edge to out_valid=1):
  - 1 cycle for single-cycle ops.
  - DATA_W+1 cycles for MUL/DIV.
- Outputs change only on transition into DONE. in_valid is ignored outside IDLE.
- Arithmetic and flag rules:
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum. ovf = (a[msb]==b[msb]) && (out[msb]!=a[msb]).
  - SUB: computed as a+~b+1. carry = no-borrow (1 when a>=b unsigned). ovf = (a[msb]!=b[msb]) && (out[msb]!=a[msb]).
  - MUL: out = low DATA_W bits of the 2*DATA_W product. carry = 1 if the high half is nonzero. ovf=0.
  - DIV: out = a/b, rem = a%b. When b==0: out = all ones, rem = a, ovf=1, and EXEC still runs the full DATA_W cycles. carry=0.
  - Logic/PASS_A: carry=0, ovf=0.
  - All ops: cero = (out==0); neg = out[DATA_W-1].

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: on ADD/SUB signed overflow, out saturates.
  - Positive overflow gives 0 followed by DATA_W-1 ones.
  - Negative overflow gives 1 followed by DATA_W-1 zeros.
  - ovf still =1. cero/neg are computed on the saturated value.
- Undefined: out wraps modulo 2^DATA_W.

Decomposition:
- Package alu_pkg:
  - opcode_t enum (3-bit, values above).
  - state_t enum {IDLE, EXEC, DONE}.
  - Localparams for opcode groups (is_iter).
- Sub-module alu_iter_core:
  - Shared DATA_W-step shift datapath for MUL/DIV: acc/quotient/count registers.
  - Ports: start, op_div, a, b, done pulse, prod_lo, prod_hi, quot, rem.
- Top module: FSM, single-cycle ops, flags, output registers.

Test Plan:
- DATA_W=8, ADD a=8'h7F b=8'h01 ci=0 → after 1 cycle out_valid=1, out=8'h80, neg=1, ovf=1, carry=0, cero=0. With ALU_SAT_EN: out=8'h7F.
- SUB a=8'h05 b=8'h05 → out=0, cero=1, carry=1, ovf=0. SUB a=8'h03 b=8'h05 → out=8'hFE, carry=0, neg=1.
- MUL a=8'd20 b=8'd13 → out_valid exactly 9 cycles after accept, out=8'h04, carry=1. in_ready=0 throughout EXEC.
- DIV a=8'd100 b=8'd7 → out=14, rem=2, latency 9. DIV a=8'd9 b=0 → out=8'hFF, rem=9, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after AND a=8'hF0 b=8'h3C → out=8'h30 stable, in_ready=0, and a concurrent in_valid is not accepted. Raise out_ready → IDLE next cycle.
- Reset mid-op: rst_n=0 on cycle 4 of a DIV → out_valid=0, all outputs 0 immediately. After release a fresh ADD 1+1 gives out=2.
